// File: rtl/inst_rom_resp_pkg.sv
// Shared fetch-path definitions for the instruction ROM responder: bus types,
// NOP encoding, fetch error codes and the address legality check.
package inst_rom_resp_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t NOP_ENC = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_OK         = 2'd0,
    FETCH_MISALIGNED = 2'd1,
    FETCH_RANGE      = 2'd2
  } fetch_err_e;

  typedef struct packed {
    logic  err;
    inst_t inst;
  } rsp_t;

  // Unsigned subtraction: addresses below base wrap and land out of range.
  function automatic fetch_err_e fetch_check(input inst_addr_t addr,
                                             input inst_addr_t base,
                                             input int unsigned depth);
    inst_addr_t off;
    off = addr - base;
    if (addr[1:0] != 2'b00) return FETCH_MISALIGNED;
    if ((off >> 2) >= inst_addr_t'(depth)) return FETCH_RANGE;
    return FETCH_OK;
  endfunction

endpackage

// File: rtl/inst_rom_resp_fifo.sv
// Two-entry fall-through valid/ready FIFO with synchronous flush; when empty,
// the incoming word is presented at the head in the same cycle.
module inst_rsp_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data,
  input  logic         i_out_ready,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_cnt;

  logic w_pop;
  logic w_pop_buf;
  logic w_store;

  assign o_out_valid = (r_cnt != 2'd0) || i_in_valid;
  assign o_out_data  = (r_cnt != 2'd0) ? r_mem[r_rd_ptr] : i_in_data;
  assign o_count     = r_cnt;

  assign w_pop     = o_out_valid && i_out_ready;
  assign w_pop_buf = w_pop && (r_cnt != 2'd0);
  // A word consumed straight through the bypass path is never stored.
  assign w_store   = i_in_valid && ((r_cnt != 2'd0) || !w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else if (i_flush) begin
      r_cnt    <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_store)   r_wr_ptr <= ~r_wr_ptr;
      if (w_pop_buf) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, w_store} - {1'b0, w_pop_buf};
    end
  end

  always_ff @(posedge clk) begin
    if (w_store && !i_flush) r_mem[r_wr_ptr] <= i_in_data;
  end

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction ROM responder: registered ROM read (S1) feeding a 2-entry output
// buffer. Define INST_ROM_PROG_PORT_EN to add a synchronous ROM write port.
module inst_rom_resp
  import inst_rom_resp_pkg::*;
#(
  parameter inst_addr_t  BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter inst_t       NOP_INST  = NOP_ENC,
  parameter inst_t       ROM_INIT [DEPTH] = '{default: NOP_INST}
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  inst_addr_t req_addr,
  input  logic       flush,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output inst_t      rsp_inst,
  output logic       rsp_err
`ifdef INST_ROM_PROG_PORT_EN
  ,
  input  logic       prog_we,
  input  inst_addr_t prog_addr,
  input  inst_t      prog_data
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic             r_s1_valid;
  logic             r_s1_err;
  inst_t            r_s1_inst;

  fetch_err_e       w_chk;
  logic [IDX_W-1:0] w_idx;
  inst_t            w_word;
  logic             w_acc;
  logic             w_pop;
  logic [1:0]       w_buf_cnt;
  logic [1:0]       w_total;
  rsp_t             w_s1_rsp;
  rsp_t             w_head;

  assign w_chk = fetch_check(req_addr, BASE_ADDR, DEPTH);
  assign w_idx = IDX_W'((req_addr - BASE_ADDR) >> 2);

`ifdef INST_ROM_PROG_PORT_EN
  inst_t            r_rom [DEPTH];
  logic             w_prog_ok;
  logic [IDX_W-1:0] w_prog_idx;

  assign w_prog_ok  = prog_we && (fetch_check(prog_addr, BASE_ADDR, DEPTH) == FETCH_OK);
  assign w_prog_idx = IDX_W'((prog_addr - BASE_ADDR) >> 2);

  // Reset reloads the boot image; a fetch in the write cycle reads old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_rom[i] <= ROM_INIT[i];
    end else if (w_prog_ok) begin
      r_rom[w_prog_idx] <= prog_data;
    end
  end

  assign w_word = r_rom[w_idx];
`else
  assign w_word = ROM_INIT[w_idx];
`endif

  // Occupancy counts S1 too, so the pipeline never holds more than two words.
  assign w_total   = {1'b0, r_s1_valid} + w_buf_cnt;
  assign w_pop     = rsp_valid && rsp_ready;
  assign req_ready = !flush && ((w_total < 2'd2) || ((w_total == 2'd2) && w_pop));
  assign w_acc     = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_inst  <= NOP_INST;
    end else begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_err  <= (w_chk != FETCH_OK);
        r_s1_inst <= (w_chk == FETCH_OK) ? w_word : NOP_INST;
      end
    end
  end

  assign w_s1_rsp = '{err: r_s1_err, inst: r_s1_inst};

  inst_rsp_fifo #(
    .W ($bits(rsp_t))
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (flush),
    .i_in_valid  (r_s1_valid),
    .i_in_data   (w_s1_rsp),
    .o_out_valid (rsp_valid),
    .o_out_data  (w_head),
    .i_out_ready (rsp_ready),
    .o_count     (w_buf_cnt)
  );

  assign rsp_inst = w_head.inst;
  assign rsp_err  = w_head.err;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Self-checking bench for inst_rom_resp: directed and random fetch streams
// checked against a request-order queue model of the fetch responder.
module tb_inst_rom_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TB_ROM [1024] = '{
    0: 32'h11, 1: 32'h22, 2: 32'h33, 3: 32'h44,
    4: 32'h5555_0004, 5: 32'h6666_0005, 6: 32'h7777_0006, 7: 32'h8888_0007,
    8: 32'h0000_0088, 9: 32'h9999_0009, 10: 32'hAAAA_000A, 11: 32'hBBBB_000B,
    12: 32'hCCCC_000C, 13: 32'hDDDD_000D, 14: 32'hEEEE_000E, 15: 32'hFFFF_000F,
    1023: 32'h3FF0_AA55, default: 32'hC0DE_0000};

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
`ifdef INST_ROM_PROG_PORT_EN
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
`endif

  logic [32:0] exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] m_rom [1024];
  int          n_cmp;
  int          n_fail;
  logic        acc;

  inst_rom_resp #(
    .ROM_INIT (TB_ROM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err)
`ifdef INST_ROM_PROG_PORT_EN
    ,
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: error on misalignment or word index beyond 1023 (base is 0).
  function automatic logic [32:0] model(input logic [31:0] a);
    if (a[1:0] != 2'b00 || a >= 32'd4096) return {1'b1, NOP};
    return {1'b0, m_rom[a[11:2]]};
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      6:       return {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      7:       return 32'h0000_0FFC;
      8:       return 32'h0000_1000 + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      9:       return 32'hFFFF_FFFC;
      default: return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0; rsp_ready = 1'b0;
    exp_q.delete();
    pend_q.delete();
    for (int i = 0; i < 1024; i++) m_rom[i] = TB_ROM[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver: one cycle of stimulus, check the combinational outputs, then advance the model
  task automatic step(input logic rv, input logic [31:0] a, input logic rr, input logic fl,
                      output logic acc_o);
    logic exp_ready;
    logic pop;
    req_valid = rv; req_addr = a; rsp_ready = rr; flush = fl;
    #1;
    exp_ready = !fl && (exp_q.size() < 2 || (exp_q.size() == 2 && rr));
    chk("req_ready", {32'd0, req_ready}, {32'd0, exp_ready});
    chk("rsp_valid", {32'd0, rsp_valid}, {32'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) chk("rsp_word", {rsp_err, rsp_inst}, exp_q[0]);
    acc_o = rv && exp_ready;
    pop   = (exp_q.size() > 0) && rr;
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (pop)   void'(exp_q.pop_front());
      if (acc_o) exp_q.push_back(model(a));
    end
    @(negedge clk);
  endtask

  // rr_mode: 0 = hold rsp_ready low, 1 = high, 2 = random
  task automatic run(input int n, input int rr_mode, input int flush_pct);
    logic rv, rr, fl, a_ok;
    for (int i = 0; i < n; i++) begin
      rv = (pend_q.size() > 0) && (rr_mode != 2 || $urandom_range(0, 3) != 0);
      rr = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
      fl = ($urandom_range(0, 99) < flush_pct);
      step(rv, rv ? pend_q[0] : 32'h0, rr, fl, a_ok);
      if (a_ok) void'(pend_q.pop_front());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
`ifdef INST_ROM_PROG_PORT_EN
    prog_we = 1'b0; prog_addr = 32'h0; prog_data = 32'h0;
`endif
    do_reset();
    #1;
    chk("reset_rsp_valid", {32'd0, rsp_valid}, 33'd0);
    chk("reset_rsp_inst", {1'b0, rsp_inst}, {1'b0, NOP});
    chk("reset_rsp_err", {32'd0, rsp_err}, 33'd0);
    chk("reset_req_ready", {32'd0, req_ready}, 33'd1);
    @(negedge clk);

    // streaming with rsp_ready held high
    pend_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    run(6, 1, 0);

    // backpressure: two accepts then stall, head held
    pend_q = '{32'h10, 32'h14, 32'h18, 32'h1C};
    run(5, 0, 0);
    chk("bp_pending_left", {1'b0, 32'(pend_q.size())}, 33'd2);
    run(8, 1, 0);

    // error cases and top word
    pend_q = '{32'h2, 32'h1000, 32'hFFC, 32'hFFFF_FFFC};
    run(7, 1, 0);

    // flush with two buffered entries and a request in the flush cycle
    pend_q = '{32'h0, 32'h4};
    run(3, 0, 0);
    step(1'b1, 32'h20, 1'b0, 1'b1, acc);
    chk("flush_no_accept", {32'd0, acc}, 33'd0);
    pend_q = '{32'h20};
    run(3, 1, 0);

    // asynchronous reset between edges
    pend_q = '{32'h24, 32'h28};
    run(2, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", {32'd0, rsp_valid}, 33'd0);
    chk("async_rst_rsp_inst", {1'b0, rsp_inst}, {1'b0, NOP});
    exp_q.delete();
    pend_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pend_q = '{32'h4};
    run(3, 1, 0);

    // random traffic with random backpressure and occasional flush
    for (int i = 0; i < 200; i++) pend_q.push_back(rand_addr());
    run(500, 2, 4);
    run(120, 1, 0);

`ifdef INST_ROM_PROG_PORT_EN
    prog_we = 1'b1; prog_addr = 32'h9; prog_data = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    prog_we = 1'b0;
    pend_q = '{32'h8};
    run(3, 1, 0);
    prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'hDEAD_BEEF;
    @(posedge clk);
    m_rom[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    prog_we = 1'b0;
    pend_q = '{32'h8};
    run(3, 1, 0);
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
